// File: rtl/general_register_file.sv
// DEPTH x WIDTH register bank: two registered read ports, one write port, range checking and sticky error.
// Define GPR_BYPASS_EN for write-first forwarding on a same-cycle read/write collision; default is read-first.
module general_register_file #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 8,
    parameter int                 SEL_W     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_a_en,
    input  logic [SEL_W-1:0] rd_a_sel,
    output logic [WIDTH-1:0] rd_a_data,
    output logic             rd_a_vld,
    input  logic             rd_b_en,
    input  logic [SEL_W-1:0] rd_b_sel,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             rd_b_vld,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    output logic             err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] regs [DEPTH];

    logic wr_in_range;
    logic a_in_range;
    logic b_in_range;
    logic wr_ok;
    logic new_err;

    // Compare at 32 bits so DEPTH=256 with SEL_W=8 still works.
    assign wr_in_range = (32'(wr_sel)   < DEPTH);
    assign a_in_range  = (32'(rd_a_sel) < DEPTH);
    assign b_in_range  = (32'(rd_b_sel) < DEPTH);

    assign wr_ok   = wr_en && wr_in_range;
    assign new_err = (wr_en   && !wr_in_range) ||
                     (rd_a_en && !a_in_range)  ||
                     (rd_b_en && !b_in_range);

    // Storage: each register decodes its own write enable.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        localparam logic [SEL_W-1:0] IDX = SEL_W'(g);
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs[g] <= RESET_VAL;
            end else if (wr_ok && (wr_sel == IDX)) begin
                regs[g] <= wr_data;
            end
        end
    end

    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_a_sel == i[SEL_W-1:0]) a_word = regs[i];
            if (rd_b_sel == i[SEL_W-1:0]) b_word = regs[i];
        end
`ifdef GPR_BYPASS_EN
        if (wr_ok && (wr_sel == rd_a_sel)) a_word = wr_data;
        if (wr_ok && (wr_sel == rd_b_sel)) b_word = wr_data;
`endif
        // Out-of-range reads return zero rather than whatever aliased entry matched.
        if (!a_in_range) a_word = '0;
        if (!b_in_range) b_word = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_data <= '0;
            rd_a_vld  <= 1'b0;
            rd_b_data <= '0;
            rd_b_vld  <= 1'b0;
            wr_ack    <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_a_vld <= rd_a_en;
            rd_b_vld <= rd_b_en;
            if (rd_a_en) rd_a_data <= a_word;
            if (rd_b_en) rd_b_data <= b_word;
            wr_ack <= wr_ok;
            // A fresh error takes priority over a clear in the same cycle.
            if (new_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_general_register_file.sv
// Table-driven bench for general_register_file (DEPTH=6, RESET_VAL=8'h42) with an expected-output queue.
module tb_general_register_file;

    localparam int               W   = 8;
    localparam int               D   = 6;
    localparam int               SW  = 3;
    localparam logic [W-1:0]     RV  = 8'h42;
`ifdef GPR_BYPASS_EN
    localparam logic [W-1:0]     COLLIDE = 8'h3C;
`else
    localparam logic [W-1:0]     COLLIDE = 8'h11;
`endif
    localparam int               EW  = 2 * W + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_a_en = 1'b0;
    logic [SW-1:0] rd_a_sel = '0;
    logic [W-1:0]  rd_a_data;
    logic          rd_a_vld;
    logic          rd_b_en = 1'b0;
    logic [SW-1:0] rd_b_sel = '0;
    logic [W-1:0]  rd_b_data;
    logic          rd_b_vld;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ack;
    logic          err;
    logic          err_clr = 1'b0;

    general_register_file #(.WIDTH(W), .DEPTH(D), .SEL_W(SW), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset),
        .rd_a_en(rd_a_en), .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data), .rd_a_vld(rd_a_vld),
        .rd_b_en(rd_b_en), .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data), .rd_b_vld(rd_b_vld),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(wr_ack),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  model [D];

    typedef struct {
        string         name;
        logic          a_en;
        logic [SW-1:0] a_sel;
        logic          b_en;
        logic [SW-1:0] b_sel;
        logic          w_en;
        logic [SW-1:0] w_sel;
        logic [W-1:0]  w_data;
        logic          clr;
        logic [W-1:0]  ea;
        logic          eav;
        logic [W-1:0]  eb;
        logic          ebv;
        logic          eack;
        logic          eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a_en, input logic [SW-1:0] a_sel,
                         input logic b_en, input logic [SW-1:0] b_sel,
                         input logic w_en, input logic [SW-1:0] w_sel,
                         input logic [W-1:0] w_data, input logic clr);
        rd_a_en = a_en; rd_a_sel = a_sel;
        rd_b_en = b_en; rd_b_sel = b_sel;
        wr_en = w_en; wr_sel = w_sel; wr_data = w_data;
        err_clr = clr;
    endtask

    task automatic check_outputs(input string name);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, ".a_data"}, rd_a_data, e[EW-1 -: W]);
            chk({name, ".a_vld"},  W'(rd_a_vld), W'(e[W+3]));
            chk({name, ".b_data"}, rd_b_data, e[W+2 -: W]);
            chk({name, ".b_vld"},  W'(rd_b_vld), W'(e[2]));
            chk({name, ".wr_ack"}, W'(wr_ack), W'(e[1]));
            chk({name, ".err"},    W'(err), W'(e[0]));
        end
    endtask

    task automatic apply(input vec_t v);
        drive(v.a_en, v.a_sel, v.b_en, v.b_sel, v.w_en, v.w_sel, v.w_data, v.clr);
        exp_q.push_back({v.ea, v.eav, v.eb, v.ebv, v.eack, v.eerr});
        tick();
        if (v.w_en && (int'(v.w_sel) < D)) model[v.w_sel] = v.w_data;
        check_outputs(v.name);
    endtask

    function automatic vec_t mk(input string n,
                                input logic a_en, input logic [SW-1:0] a_sel,
                                input logic b_en, input logic [SW-1:0] b_sel,
                                input logic w_en, input logic [SW-1:0] w_sel, input logic [W-1:0] w_data,
                                input logic clr,
                                input logic [W-1:0] ea, input logic eav,
                                input logic [W-1:0] eb, input logic ebv,
                                input logic eack, input logic eerr);
        vec_t v;
        v.name = n; v.a_en = a_en; v.a_sel = a_sel; v.b_en = b_en; v.b_sel = b_sel;
        v.w_en = w_en; v.w_sel = w_sel; v.w_data = w_data; v.clr = clr;
        v.ea = ea; v.eav = eav; v.eb = eb; v.ebv = ebv; v.eack = eack; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < D; i++) model[i] = RV;

        // Reset: outputs zero while held and just after release.
        tick();
        tick();
        reset = 1'b0;
        chk("rst.a_data", rd_a_data, '0);
        chk("rst.b_data", rd_b_data, '0);
        chk("rst.flags", W'({rd_a_vld, rd_b_vld, wr_ack, err}), '0);

        // Every valid index on both ports reads RESET_VAL, vld one cycle later.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, SW'(i), 1'b1, SW'(D - 1 - i), 1'b0, '0, '0, 1'b0);
            exp_q.push_back({RV, 1'b1, RV, 1'b1, 1'b0, 1'b0});
            tick();
            check_outputs($sformatf("rst_rd%0d", i));
        end

        //             name          aen a  ben b  wen ws data   clr  ea      eav eb     ebv ack err
        vecs.push_back(mk("wr_r3",     0, 0, 0, 0, 1, 3, 8'hA5, 0, RV,     0, RV,    0,  1,  0));
        vecs.push_back(mk("rd_r3",     1, 3, 0, 0, 0, 0, 8'h00, 0, 8'hA5,  1, RV,    0,  0,  0));
        vecs.push_back(mk("wr_r5",     0, 0, 0, 0, 1, 5, 8'h11, 0, 8'hA5,  0, RV,    0,  1,  0));
        vecs.push_back(mk("collide_r5",1, 5, 0, 0, 1, 5, 8'h3C, 0, COLLIDE,1, RV,    0,  1,  0));
        vecs.push_back(mk("rd_r5",     1, 5, 0, 0, 0, 0, 8'h00, 0, 8'h3C,  1, RV,    0,  0,  0));
        vecs.push_back(mk("wr_r2",     0, 0, 0, 0, 1, 2, 8'h5A, 0, 8'h3C,  0, RV,    0,  1,  0));
        vecs.push_back(mk("rd_ab_r2",  1, 2, 1, 2, 0, 0, 8'h00, 0, 8'h5A,  1, 8'h5A, 1,  0,  0));
        vecs.push_back(mk("idle_hold", 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h5A,  0, 8'h5A, 0,  0,  0));
        vecs.push_back(mk("wr_oor7",   0, 0, 0, 0, 1, 7, 8'hFF, 0, 8'h5A,  0, 8'h5A, 0,  0,  1));
        vecs.push_back(mk("rd_b_oor6", 0, 0, 1, 6, 0, 0, 8'h00, 0, 8'h5A,  0, 8'h00, 1,  0,  1));
        vecs.push_back(mk("err_sticky",1, 0, 0, 0, 0, 0, 8'h00, 0, RV,     1, 8'h00, 0,  0,  1));
        vecs.push_back(mk("err_clr",   0, 0, 0, 0, 0, 0, 8'h00, 1, RV,     0, 8'h00, 0,  0,  0));
        vecs.push_back(mk("clr_vs_err",1, 6, 0, 0, 0, 0, 8'h00, 1, 8'h00,  1, 8'h00, 0,  0,  1));
        vecs.push_back(mk("err_clr2",  0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00,  0, 8'h00, 0,  0,  0));
        vecs.push_back(mk("wr_oor6",   0, 0, 0, 0, 1, 6, 8'hEE, 0, 8'h00,  0, 8'h00, 0,  0,  1));
        vecs.push_back(mk("rd_b_r3",   0, 0, 1, 3, 0, 0, 8'h00, 1, 8'h00,  0, 8'hA5, 1,  0,  0));
        foreach (vecs[k]) apply(vecs[k]);

        // Out-of-range writes must not have touched any register.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, SW'(i), 1'b1, SW'(i), 1'b0, '0, '0, 1'b0);
            exp_q.push_back({model[i], 1'b1, model[i], 1'b1, 1'b0, 1'b0});
            tick();
            check_outputs($sformatf("readback%0d", i));
        end

        // Async reset mid-cycle during a write to R1, with flags and data set beforehand.
        drive(1'b1, 3'd7, 1'b1, 3'd3, 1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 3'd1, 8'h77, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.a_data", rd_a_data, '0);
        chk("arst.b_data", rd_b_data, '0);
        chk("arst.flags", W'({rd_a_vld, rd_b_vld, wr_ack, err}), '0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b0, '0, '0, 1'b0);
        exp_q.push_back({RV, 1'b1, RV, 1'b1, 1'b0, 1'b0});
        tick();
        check_outputs("arst_rd_r1_r3");

        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
